serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL be an integer with default 8 and legal range 1..64; it sets the operand width in bits.
REQ-002 Port clk SHALL be an input of 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input of 1 bit: reset, synchronous, active-low.
REQ-004 Port start SHALL be an input of 1 bit: operation request, sampled on the clock edge.
REQ-005 Port a SHALL be an input of WIDTH bits: operand A, captured on an accepted start.
REQ-006 Port b SHALL be an input of WIDTH bits: operand B, captured on an accepted start.
REQ-007 Port cin SHALL be an input of 1 bit: carry-in, captured on an accepted start.
REQ-008 Port busy SHALL be an output of 1 bit: high while the state is RUN.
REQ-009 Port done SHALL be an output of 1 bit: a one-cycle pulse in state DONE.
REQ-010 Port sum SHALL be an output of WIDTH bits: the result, valid from done and held until the next accepted start.
REQ-011 Port cout SHALL be an output of 1 bit: the final carry, with the same validity as sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, using one full_adder instance and a carry flip-flop.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on an edge with start=1; that edge loads operand shift registers with a and b, loads carry with cin, clears the bit counter, and sets sum to 0.
REQ-015 In RUN, each edge SHALL shift the full_adder s output into the sum MSB (sum shifts right), store cout into carry, shift the operands right, and increment the counter.
REQ-016 RUN->DONE SHALL occur on the edge that processes bit WIDTH-1; busy is high for exactly WIDTH cycles.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and sum and cout are valid in that same cycle.
REQ-018 DONE->IDLE SHALL occur on the next edge when start=0; DONE->RUN on that edge when start=1, with the new operands accepted (back-to-back, no idle cycle).
REQ-019 A start asserted during RUN SHALL be ignored, with no effect on operands or result.
REQ-020 The sum and cout outputs SHALL stay stable in IDLE and change only in RUN.
REQ-021 With WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-022 While rst_n=0 at an edge: state SHALL be IDLE and busy, done, sum, cout, carry, counter and the operand registers SHALL all be 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation: no done pulse, and the partial result is discarded.
REQ-024 The first start after reset release SHALL be accepted normally.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output ovf (1 bit): signed overflow, equal to the carry into the MSB XOR cout, with the same validity as sum and a reset value of 0.
REQ-026 When SERIAL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the localparam for the default WIDTH.
REQ-028 The counter width SHALL be $clog2(WIDTH+1), derived in the module.
REQ-029 The sub-module SHALL be the existing full_adder (a, b, cin -> s, cout), instantiated once, with no other sub-modules.

Verification
REQ-030 WIDTH=8: a=0xFF, b=0x01, cin=0, start at edge k -> done in the cycle after edge k+8, sum=0x00, cout=1.
REQ-031 WIDTH=8: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, and ovf=1 when SERIAL_ADDER_OVF_EN is defined.
REQ-032 Start pulsed with a=0x12, b=0x34, then start again mid-RUN with a=0xFF -> one done only, sum=0x46, cout=0.
REQ-033 rst_n=0 for one edge at RUN bit 3 -> no done; busy, sum and cout = 0; a following start with a=0x05, b=0x03, cin=1 -> sum=0x09.
REQ-034 Start held high through DONE -> second operation begins on the DONE edge, busy rises with no IDLE cycle, and done pulses every 9 cycles.
REQ-035 WIDTH=1: a=1, b=1, cin=1 -> done in the cycle after edge k+1, sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Operand width used when the instantiating context does not override it.
  localparam int unsigned DefaultWidth = 8;

  // Control states of the serial adder sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder: the one arithmetic cell reused every cycle by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic w_load;
  logic w_step;
  logic w_last;
  logic w_fa_s;
  logic w_fa_cout;

  // The single adder cell always sees the current LSBs and the running carry.
  full_adder u_full_adder (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .cout(w_fa_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and status outputs; a DONE with start held restarts immediately.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LastBit) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // New result bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    w_sum_shift             = r_sum >> 1;
    w_sum_shift[WIDTH-1]    = w_fa_s;
  end

  // Datapath: operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_step) begin
      r_sum   <= w_sum_shift;
      r_carry <= w_fa_cout;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CntW'(1);
      if (w_last) begin
        r_cout <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
        // r_carry holds the carry into the MSB while the MSB is being added.
        r_ovf  <= r_carry ^ w_fa_cout;
`endif
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances), scoreboard based.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   dcnt8   = 0;
  exp_t q8[$];
  exp_t q1[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf1)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done8) dcnt8 <= dcnt8 + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition truncated to w bits.
  function automatic exp_t model(input int unsigned w, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    int unsigned full, mask;
    exp_t e;
    mask   = (32'd1 << w) - 1;
    full   = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
    e.sum  = 8'(full & mask);
    e.cout = ((full >> w) & 32'd1) != 0;
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic wait_done8(output int at_cyc, output int lat);
    exp_t e;
    bit   seen = 0;
    lat = 0;
    at_cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done8) begin
        seen   = 1;
        at_cyc = cyc;
        check_eq("sb8_pending", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check_eq("sum8", 32'(sum8), 32'(e.sum));
          check_eq("cout8", 32'(cout8), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check_eq("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
        end
        check_eq("busy8_at_done", 32'(busy8), 0);
      end
    end
    check_eq("done8_seen", 32'(seen), 1);
  endtask

  task automatic wait_done1(output int lat);
    exp_t e;
    bit   seen = 0;
    lat = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done1) begin
        seen = 1;
        check_eq("sb1_pending", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check_eq("sum1", 32'(sum1), 32'(e.sum));
          check_eq("cout1", 32'(cout1), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check_eq("ovf1", 32'(ovf1), 32'(e.ovf));
`endif
        end
      end
    end
    check_eq("done1_seen", 32'(seen), 1);
  endtask

  // One isolated WIDTH=8 operation; caller is positioned just after a negedge.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    exp_t e;
    int   c, lat;
    e = model(8, a, b, cin);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    cin8 = cin;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    check_eq("busy8_rise", 32'(busy8), 1);
    wait_done8(c, lat);
    check_eq("latency8", 32'(lat), 8);
    @(negedge clk);
    check_eq("done8_pulse", 32'(done8), 0);
    check_eq("busy8_idle", 32'(busy8), 0);
    repeat (3) @(negedge clk);
    check_eq("sum8_hold", 32'(sum8), 32'(e.sum));
    check_eq("cout8_hold", 32'(cout8), 32'(e.cout));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, t1, t2, t3, lat;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy8", 32'(busy8), 0);
    check_eq("rst_done8", 32'(done8), 0);
    check_eq("rst_sum8", 32'(sum8), 0);
    check_eq("rst_cout8", 32'(cout8), 0);
    check_eq("rst_busy1", 32'(busy1), 0);
    check_eq("rst_sum1", 32'(sum1), 0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("rst_ovf8", 32'(ovf8), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_op8(8'hFF, 8'h01, 1'b0);
    do_op8(8'h7F, 8'h01, 1'b0);
    do_op8(8'hA5, 8'h5A, 1'b1);

    // Start during RUN must be ignored.
    d0 = dcnt8;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back(model(8, 8'h12, 8'h34, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(t1, lat);
    repeat (12) @(negedge clk);
    check_eq("ignored_start_dones", 32'(dcnt8 - d0), 1);
    check_eq("ignored_start_busy", 32'(busy8), 0);

    // Reset while bit 3 is about to be processed aborts the operation.
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0;
    q8.push_back(model(8, 8'hAA, 8'h11, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(busy8), 0);
    check_eq("abort_done", 32'(done8), 0);
    check_eq("abort_sum", 32'(sum8), 0);
    check_eq("abort_cout", 32'(cout8), 0);
    check_eq("abort_sb", 32'(q8.size()), 1);
    q8.delete();
    d0 = dcnt8;
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", 32'(dcnt8 - d0), 0);
    do_op8(8'h05, 8'h03, 1'b1);

    // Back-to-back: start held high through DONE.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    q8.push_back(model(8, 8'h10, 8'h20, 1'b0));
    @(negedge clk);
    check_eq("b2b_busy0", 32'(busy8), 1);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    q8.push_back(model(8, 8'h80, 8'h80, 1'b1));
    wait_done8(t1, lat);
    @(negedge clk);
    check_eq("b2b_busy1", 32'(busy8), 1);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
    q8.push_back(model(8, 8'h33, 8'h44, 1'b1));
    wait_done8(t2, lat);
    check_eq("b2b_period1", 32'(t2 - t1), 9);
    @(negedge clk);
    check_eq("b2b_busy2", 32'(busy8), 1);
    start8 = 1'b0;
    wait_done8(t3, lat);
    check_eq("b2b_period2", 32'(t3 - t2), 9);
    @(negedge clk);
    check_eq("b2b_end_busy", 32'(busy8), 0);

    // WIDTH=1 instance.
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    q1.push_back(model(1, 8'h01, 8'h01, 1'b1));
    @(negedge clk);
    start1 = 1'b0;
    check_eq("w1_busy", 32'(busy1), 1);
    wait_done1(lat);
    check_eq("w1_latency", 32'(lat), 1);
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    q1.push_back(model(1, 8'h01, 8'h00, 1'b0));
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(lat);
    check_eq("w1_latency2", 32'(lat), 1);
    @(negedge clk);
    check_eq("w1_idle", 32'(busy1), 0);

    check_eq("sb8_empty", 32'(q8.size()), 0);
    check_eq("sb1_empty", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_serial_adder
